// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions for the ID/EX stage and its neighbours.
//   DATA_W / REG_AW : default datapath and register-specifier widths
//   alu_op_e        : ALU operation class carried down the pipe
//   ctrl_t          : packed control bundle; an all-zero value is a bubble
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  // Zeroing the whole bundle is what turns a slot into a no-op.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg_if
// Bundles every non-clock/reset signal of the ID/EX register.
//   master : ID stage / WB stage / branch unit side (drives ID_*, WB_*, Flush)
//   slave  : the ID/EX register itself (drives Stall, EX_*, Bubble_Cnt)
// -----------------------------------------------------------------------------
interface id_ex_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
);

  // ID side
  logic              ID_Valid;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic [REG_AW-1:0] ID_Rd;
  logic              ID_UsesRt;
  logic [DATA_W-1:0] ID_RD1;
  logic [DATA_W-1:0] ID_RD2;
  logic [DATA_W-1:0] ID_Imm;
  logic [DATA_W-1:0] ID_PC4;
  logic              ID_RegWrite;
  logic              ID_MemtoReg;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_ALUSrc;
  logic              ID_RegDst;
  logic [1:0]        ID_ALUOp;

  // WB write port (mirrors the register file write)
  logic              WB_RegWrite;
  logic [REG_AW-1:0] WB_WN;
  logic [DATA_W-1:0] WB_WD;

  logic              Flush;
  logic              Stall;

  // EX side
  logic              EX_Valid;
  logic [REG_AW-1:0] EX_Rs;
  logic [REG_AW-1:0] EX_Rt;
  logic [REG_AW-1:0] EX_Rd;
  logic [DATA_W-1:0] EX_RD1;
  logic [DATA_W-1:0] EX_RD2;
  logic [DATA_W-1:0] EX_Imm;
  logic [DATA_W-1:0] EX_PC4;
  logic              EX_RegWrite;
  logic              EX_MemtoReg;
  logic              EX_MemRead;
  logic              EX_MemWrite;
  logic              EX_ALUSrc;
  logic              EX_RegDst;
  logic [1:0]        EX_ALUOp;
  logic [CNT_W-1:0]  Bubble_Cnt;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, ID_RD1, ID_RD2, ID_Imm, ID_PC4,
           ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, WB_RegWrite, WB_WN, WB_WD, Flush,
    input  Stall, EX_Valid, EX_Rs, EX_Rt, EX_Rd, EX_RD1, EX_RD2, EX_Imm, EX_PC4,
           EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst,
           EX_ALUOp, Bubble_Cnt
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, ID_RD1, ID_RD2, ID_Imm, ID_PC4,
           ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, WB_RegWrite, WB_WN, WB_WD, Flush,
    output Stall, EX_Valid, EX_Rs, EX_Rt, EX_Rd, EX_RD1, EX_RD2, EX_Imm, EX_PC4,
           EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst,
           EX_ALUOp, Bubble_Cnt
  );

endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. Flags when the instruction now in
// EX is a load whose destination (Rt) is a source of the instruction in ID.
//   ex_mem_read, ex_valid, ex_rt : state of the instruction in EX
//   id_valid, id_rs, id_rt       : instruction in ID
//   id_uses_rt                   : ID instruction really reads Rt
//   stall                        : hold PC and IF/ID, bubble into EX
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              stall
);

  // A load into r0 produces nothing to wait for, so it never stalls.
  always_comb begin
    stall = 1'b0;
    if (ex_mem_read && ex_valid && (ex_rt != '0) && id_valid) begin
      stall = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register directly after the register file.
//   Clk, Rst_n : clock and asynchronous active-low reset
//   bus        : slave side of id_ex_stage_reg_if (ID inputs, WB write port,
//                Flush in; Stall, registered EX_* copies, Bubble_Cnt out)
// The register file writes on the clock edge and reads combinationally, so a
// WB write landing on the same edge is forwarded into RD1/RD2 here. Load-use
// hazards and flushes load a bubble; bubbles caused by a real ID instruction
// are counted in a saturating counter.
// -----------------------------------------------------------------------------
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input logic              Clk,
  input logic              Rst_n,
  id_ex_stage_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              stall;
  logic              load_bubble;
  logic              wb_hit_rs;
  logic              wb_hit_rt;
  logic [DATA_W-1:0] rd1_byp;
  logic [DATA_W-1:0] rd2_byp;
  ctrl_t             ctrl_id;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .ex_mem_read(ctrl_q.mem_read),
    .ex_valid   (valid_q),
    .ex_rt      (rt_q),
    .id_valid   (bus.ID_Valid),
    .id_uses_rt (bus.ID_UsesRt),
    .id_rs      (bus.ID_Rs),
    .id_rt      (bus.ID_Rt),
    .stall      (stall)
  );

  // Write-through bypass: r0 is hardwired zero and must never pick up WB data.
  always_comb begin
    wb_hit_rs = bus.WB_RegWrite && (bus.WB_WN != '0) && (bus.WB_WN == bus.ID_Rs);
    wb_hit_rt = bus.WB_RegWrite && (bus.WB_WN != '0) && (bus.WB_WN == bus.ID_Rt);
    rd1_byp   = wb_hit_rs ? bus.WB_WD : bus.ID_RD1;
    rd2_byp   = wb_hit_rt ? bus.WB_WD : bus.ID_RD2;
  end

  always_comb begin
    ctrl_id            = CTRL_BUBBLE;
    ctrl_id.reg_write  = bus.ID_RegWrite;
    ctrl_id.mem_to_reg = bus.ID_MemtoReg;
    ctrl_id.mem_read   = bus.ID_MemRead;
    ctrl_id.mem_write  = bus.ID_MemWrite;
    ctrl_id.alu_src    = bus.ID_ALUSrc;
    ctrl_id.reg_dst    = bus.ID_RegDst;
    ctrl_id.alu_op     = alu_op_e'(bus.ID_ALUOp);
  end

  // Flush outranks Stall, but both simply load a bubble, so they share one
  // path; the counter therefore advances at most once per edge.
  always_comb begin
    load_bubble = bus.Flush || stall;
    valid_d     = 1'b0;
    rs_d        = '0;
    rt_d        = '0;
    rd_d        = '0;
    rd1_d       = '0;
    rd2_d       = '0;
    imm_d       = '0;
    pc4_d       = '0;
    ctrl_d      = CTRL_BUBBLE;
    cnt_d       = cnt_q;
    if (!load_bubble) begin
      valid_d = bus.ID_Valid;
      rs_d    = bus.ID_Rs;
      rt_d    = bus.ID_Rt;
      rd_d    = bus.ID_Rd;
      rd1_d   = rd1_byp;
      rd2_d   = rd2_byp;
      imm_d   = bus.ID_Imm;
      pc4_d   = bus.ID_PC4;
      ctrl_d  = ctrl_id;
    end
    if (load_bubble && bus.ID_Valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      ctrl_q  <= CTRL_BUBBLE;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Stall       = stall;
  assign bus.EX_Valid    = valid_q;
  assign bus.EX_Rs       = rs_q;
  assign bus.EX_Rt       = rt_q;
  assign bus.EX_Rd       = rd_q;
  assign bus.EX_RD1      = rd1_q;
  assign bus.EX_RD2      = rd2_q;
  assign bus.EX_Imm      = imm_q;
  assign bus.EX_PC4      = pc4_q;
  assign bus.EX_RegWrite = ctrl_q.reg_write;
  assign bus.EX_MemtoReg = ctrl_q.mem_to_reg;
  assign bus.EX_MemRead  = ctrl_q.mem_read;
  assign bus.EX_MemWrite = ctrl_q.mem_write;
  assign bus.EX_ALUSrc   = ctrl_q.alu_src;
  assign bus.EX_RegDst   = ctrl_q.reg_dst;
  assign bus.EX_ALUOp    = ctrl_q.alu_op;
  assign bus.Bubble_Cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed scoreboard bench for id_ex_stage_reg. The counter is built 2 bits
// wide so that saturation is reachable in a handful of cycles.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  // ctrl packing used throughout: {RegWrite, MemtoReg, MemRead, MemWrite,
  // ALUSrc, RegDst, ALUOp[1:0]}
  typedef struct {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          uses_rt;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [7:0]    ctrl;
    logic          wb_we;
    logic [AW-1:0] wb_wn;
    logic [DW-1:0] wb_wd;
    logic          flush;
  } vec_t;

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [7:0]    ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;

  always #5 Clk = ~Clk;

  id_ex_stage_reg_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  int    checks = 0;
  int    fails = 0;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t idleVec();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic exp_t capExp(input vec_t v, input logic [DW-1:0] rd1,
                                  input logic [DW-1:0] rd2, input logic [CW-1:0] cnt);
    exp_t e;
    e.valid = v.valid;
    e.rs    = v.rs;
    e.rt    = v.rt;
    e.rd    = v.rd;
    e.rd1   = rd1;
    e.rd2   = rd2;
    e.imm   = v.imm;
    e.pc4   = v.pc4;
    e.ctrl  = v.ctrl;
    e.cnt   = cnt;
    return e;
  endfunction

  function automatic exp_t bubExp(input logic [CW-1:0] cnt);
    exp_t e;
    e     = '{default: '0};
    e.cnt = cnt;
    return e;
  endfunction

  task automatic driveVec(input vec_t v);
    bus.ID_Valid    = v.valid;
    bus.ID_Rs       = v.rs;
    bus.ID_Rt       = v.rt;
    bus.ID_Rd       = v.rd;
    bus.ID_UsesRt   = v.uses_rt;
    bus.ID_RD1      = v.rd1;
    bus.ID_RD2      = v.rd2;
    bus.ID_Imm      = v.imm;
    bus.ID_PC4      = v.pc4;
    bus.ID_RegWrite = v.ctrl[7];
    bus.ID_MemtoReg = v.ctrl[6];
    bus.ID_MemRead  = v.ctrl[5];
    bus.ID_MemWrite = v.ctrl[4];
    bus.ID_ALUSrc   = v.ctrl[3];
    bus.ID_RegDst   = v.ctrl[2];
    bus.ID_ALUOp    = v.ctrl[1:0];
    bus.WB_RegWrite = v.wb_we;
    bus.WB_WN       = v.wb_wn;
    bus.WB_WD       = v.wb_wd;
    bus.Flush       = v.flush;
  endtask

  // Drive one ID-stage vector shortly after an edge, check the combinational
  // Stall it provokes, and queue what EX must hold after the next edge.
  task automatic applyStimulus(input string name, input vec_t v, input exp_t e,
                               input logic exp_stall);
    @(posedge Clk);
    #2;
    driveVec(v);
    #1;
    checkOutput({name, ".stall"}, 32'(bus.Stall), 32'(exp_stall));
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  function automatic logic [7:0] exCtrl();
    return {bus.EX_RegWrite, bus.EX_MemtoReg, bus.EX_MemRead, bus.EX_MemWrite,
            bus.EX_ALUSrc, bus.EX_RegDst, bus.EX_ALUOp};
  endfunction

  // Monitor: each edge presents a new EX slot; compare it against the oldest
  // queued expectation.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checkOutput({mon_n, ".valid"}, 32'(bus.EX_Valid), 32'(mon_e.valid));
      checkOutput({mon_n, ".rs"}, 32'(bus.EX_Rs), 32'(mon_e.rs));
      checkOutput({mon_n, ".rt"}, 32'(bus.EX_Rt), 32'(mon_e.rt));
      checkOutput({mon_n, ".rd"}, 32'(bus.EX_Rd), 32'(mon_e.rd));
      checkOutput({mon_n, ".rd1"}, bus.EX_RD1, mon_e.rd1);
      checkOutput({mon_n, ".rd2"}, bus.EX_RD2, mon_e.rd2);
      checkOutput({mon_n, ".imm"}, bus.EX_Imm, mon_e.imm);
      checkOutput({mon_n, ".pc4"}, bus.EX_PC4, mon_e.pc4);
      checkOutput({mon_n, ".ctrl"}, 32'(exCtrl()), 32'(mon_e.ctrl));
      checkOutput({mon_n, ".cnt"}, 32'(bus.Bubble_Cnt), 32'(mon_e.cnt));
    end
  end

  vec_t vLw;
  vec_t v;

  initial begin
    driveVec(idleVec());

    // Reset state
    #8;
    checkOutput("rst.valid", 32'(bus.EX_Valid), 32'd0);
    checkOutput("rst.rd1", bus.EX_RD1, 32'd0);
    checkOutput("rst.ctrl", 32'(exCtrl()), 32'd0);
    checkOutput("rst.cnt", 32'(bus.Bubble_Cnt), 32'd0);
    checkOutput("rst.stall", 32'(bus.Stall), 32'd0);
    #4;
    Rst_n = 1'b1;

    // Plain capture
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd2; v.rt = 5'd3; v.rd = 5'd4;
    v.rd1 = 32'h0000_00AA; v.rd2 = 32'h0000_00BB;
    v.imm = 32'hFFFF_FFF0; v.pc4 = 32'h0000_0104; v.ctrl = 8'b1000_0110;
    applyStimulus("capture", v, capExp(v, 32'h0000_00AA, 32'h0000_00BB, 2'd0), 1'b0);

    // WB bypass into RD1
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd1; v.rt = 5'd6; v.rd1 = 32'h0; v.rd2 = 32'h66;
    v.ctrl = 8'b1000_0110; v.wb_we = 1'b1; v.wb_wn = 5'd1; v.wb_wd = 32'h1234_5678;
    applyStimulus("byp_rs", v, capExp(v, 32'h1234_5678, 32'h66, 2'd0), 1'b0);

    // WB bypass into RD2 only
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd9; v.rt = 5'd7; v.rd1 = 32'h99; v.rd2 = 32'h77;
    v.wb_we = 1'b1; v.wb_wn = 5'd7; v.wb_wd = 32'hCAFE_F00D;
    applyStimulus("byp_rt", v, capExp(v, 32'h99, 32'hCAFE_F00D, 2'd0), 1'b0);

    // Matching WN but write disabled: no bypass
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd9; v.rd1 = 32'h99; v.rd2 = 32'h22;
    v.wb_we = 1'b0; v.wb_wn = 5'd9; v.wb_wd = 32'h1111_1111;
    applyStimulus("byp_off", v, capExp(v, 32'h99, 32'h22, 2'd0), 1'b0);

    // Register 0 is never bypassed
    v = idleVec();
    v.valid = 1'b1; v.rd1 = 32'h55; v.rd2 = 32'h44;
    v.wb_we = 1'b1; v.wb_wn = 5'd0; v.wb_wd = 32'hDEAD_BEEF;
    applyStimulus("byp_r0", v, capExp(v, 32'h55, 32'h44, 2'd0), 1'b0);

    // Load-use through Rs: lw r5 then add using r5
    vLw = idleVec();
    vLw.valid = 1'b1; vLw.rs = 5'd1; vLw.rt = 5'd5; vLw.rd1 = 32'h1000; vLw.rd2 = 32'h5;
    vLw.imm = 32'h8; vLw.pc4 = 32'h200; vLw.ctrl = 8'b1110_1000;
    applyStimulus("lw_a", vLw, capExp(vLw, 32'h1000, 32'h5, 2'd0), 1'b0);
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd5; v.rt = 5'd6; v.rd = 5'd7; v.uses_rt = 1'b1;
    v.rd1 = 32'h50; v.rd2 = 32'h60; v.pc4 = 32'h204; v.ctrl = 8'b1000_0110;
    applyStimulus("use_rs_stall", v, bubExp(2'd1), 1'b1);
    applyStimulus("use_rs_held", v, capExp(v, 32'h50, 32'h60, 2'd1), 1'b0);

    // Rt match but Rt not read: no stall
    applyStimulus("lw_b", vLw, capExp(vLw, 32'h1000, 32'h5, 2'd1), 1'b0);
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd3; v.rt = 5'd5; v.rd = 5'd4; v.uses_rt = 1'b0;
    v.rd1 = 32'h30; v.rd2 = 32'h31; v.imm = 32'h4; v.ctrl = 8'b1000_1000;
    applyStimulus("no_use_rt", v, capExp(v, 32'h30, 32'h31, 2'd1), 1'b0);

    // Load-use through Rt
    applyStimulus("lw_c", vLw, capExp(vLw, 32'h1000, 32'h5, 2'd1), 1'b0);
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd2; v.rt = 5'd5; v.rd = 5'd9; v.uses_rt = 1'b1;
    v.rd1 = 32'h20; v.rd2 = 32'h21; v.ctrl = 8'b1000_0101;
    applyStimulus("use_rt_stall", v, bubExp(2'd2), 1'b1);
    applyStimulus("use_rt_held", v, capExp(v, 32'h20, 32'h21, 2'd2), 1'b0);

    // Flush and stall together: one bubble, one count
    vLw.rt = 5'd8;
    applyStimulus("lw_d", vLw, capExp(vLw, 32'h1000, 32'h5, 2'd2), 1'b0);
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd8; v.rd = 5'd10; v.rd1 = 32'h80; v.ctrl = 8'b1000_0110;
    v.flush = 1'b1;
    applyStimulus("flush_stall", v, bubExp(2'd3), 1'b1);
    v.flush = 1'b0;
    applyStimulus("after_flush", v, capExp(v, 32'h80, 32'h0, 2'd3), 1'b0);

    // Flush of an empty slot does not count
    v = idleVec();
    v.flush = 1'b1;
    applyStimulus("flush_invalid", v, bubExp(2'd3), 1'b0);

    // Reset dropped between edges clears state without a clock edge
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd1; v.rd1 = 32'h77; v.ctrl = 8'b1000_0000;
    applyStimulus("pre_reset", v, capExp(v, 32'h77, 32'h0, 2'd3), 1'b0);
    @(posedge Clk);
    #3;
    driveVec(idleVec());
    Rst_n = 1'b0;
    #1;
    checkOutput("midrst.regwrite", 32'(bus.EX_RegWrite), 32'd0);
    checkOutput("midrst.valid", 32'(bus.EX_Valid), 32'd0);
    checkOutput("midrst.rd1", bus.EX_RD1, 32'd0);
    checkOutput("midrst.cnt", 32'(bus.Bubble_Cnt), 32'd0);
    checkOutput("midrst.stall", 32'(bus.Stall), 32'd0);
    #3;
    Rst_n = 1'b1;

    // First edge after release captures normally
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd4; v.rd1 = 32'h1234; v.pc4 = 32'h8; v.ctrl = 8'b1000_0001;
    applyStimulus("post_reset", v, capExp(v, 32'h1234, 32'h0, 2'd0), 1'b0);

    // Saturation with a 2-bit counter: 1,2,3,3,3
    v = idleVec();
    v.valid = 1'b1; v.rs = 5'd1; v.ctrl = 8'b1000_0000; v.flush = 1'b1;
    applyStimulus("sat1", v, bubExp(2'd1), 1'b0);
    applyStimulus("sat2", v, bubExp(2'd2), 1'b0);
    applyStimulus("sat3", v, bubExp(2'd3), 1'b0);
    applyStimulus("sat4", v, bubExp(2'd3), 1'b0);
    applyStimulus("sat5", v, bubExp(2'd3), 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
    #2;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
